// File: rtl/cbfp_pkg.sv
// Shared widths, defaults and types for the CBFP denormalizer slice.
package cbfp_pkg;

  localparam int DEF_BW_IN           = 11;
  localparam int DEF_BW_OUT          = 23;
  localparam int DEF_IDX_W           = 5;
  localparam int DEF_TARGET_INT_BITS = 12;
  localparam int DEF_BLOCK_SIZE      = 64;
  localparam int DEF_BATCH_SIZE      = 16;
  localparam int BATCHES_PER_BLOCK   = DEF_BLOCK_SIZE / DEF_BATCH_SIZE;

  typedef logic signed [DEF_BW_IN-1:0]  sample_in_t;
  typedef logic signed [DEF_BW_OUT-1:0] sample_out_t;
  typedef logic        [DEF_IDX_W-1:0]  index_t;

  // Counter width that stays legal even for a single-batch block.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbfp_lane_scale.sv
// Combinational rescale of one value by 2^d (floor on right shifts), saturated to BW_OUT.
module cbfp_lane_scale #(
  parameter int BW_IN           = 11,
  parameter int BW_OUT          = 23,
  parameter int D_W             = 6,
  parameter int TARGET_INT_BITS = 12
) (
  input  logic signed [BW_IN-1:0]  x,
  input  logic signed [D_W-1:0]    d,
  output logic signed [BW_OUT-1:0] y
);

  localparam int EW = BW_OUT + TARGET_INT_BITS;
  localparam logic signed [EW-1:0] SAT_MAX = EW'((longint'(1) <<< (BW_OUT - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shifted;
  logic        [D_W-1:0] mag;

  assign ext = EW'(x);

  // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    mag     = unsigned'(d[D_W-1] ? -d : d);
    shifted = d[D_W-1] ? (ext >>> mag) : (ext <<< mag);
    if (shifted > SAT_MAX)
      y = SAT_MAX[BW_OUT-1:0];
    else if (shifted < SAT_MIN)
      y = SAT_MIN[BW_OUT-1:0];
    else
      y = shifted[BW_OUT-1:0];
  end

endmodule

// File: rtl/cbfp_denorm.sv
// Two-stage CBFP denormalizer: per-lane rescale, block framing and index-consistency flag.
module cbfp_denorm
  import cbfp_pkg::*;
#(
  parameter int BW_IN           = DEF_BW_IN,
  parameter int BW_OUT          = DEF_BW_OUT,
  parameter int IDX_W           = DEF_IDX_W,
  parameter int TARGET_INT_BITS = DEF_TARGET_INT_BITS,
  parameter int BLOCK_SIZE      = DEF_BLOCK_SIZE,
  parameter int BATCH_SIZE      = DEF_BATCH_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [BW_IN-1:0]  real_in  [0:BATCH_SIZE-1],
  input  logic signed [BW_IN-1:0]  imag_in  [0:BATCH_SIZE-1],
  input  logic        [IDX_W-1:0]  index_in [0:BATCH_SIZE-1],
  output logic signed [BW_OUT-1:0] real_out [0:BATCH_SIZE-1],
  output logic signed [BW_OUT-1:0] imag_out [0:BATCH_SIZE-1],
  output logic                     valid_out,
  output logic                     block_start,
  output logic                     block_end,
  output logic                     idx_err
);

  localparam int D_W   = IDX_W + 1;
  localparam int NB    = BLOCK_SIZE / BATCH_SIZE;
  localparam int CNT_W = cnt_width(NB);
  localparam logic signed [D_W-1:0] TIB_S    = D_W'(TARGET_INT_BITS);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(NB - 1);

  logic [CNT_W-1:0] batch_cnt;
  logic [IDX_W-1:0] ref_idx;
  logic             err_acc;

  logic                    s1_valid, s1_first, s1_last, s1_err;
  logic signed [BW_IN-1:0] s1_real [0:BATCH_SIZE-1];
  logic signed [BW_IN-1:0] s1_imag [0:BATCH_SIZE-1];
  logic signed [D_W-1:0]   s1_d    [0:BATCH_SIZE-1];

  logic signed [BW_OUT-1:0] sc_real [0:BATCH_SIZE-1];
  logic signed [BW_OUT-1:0] sc_imag [0:BATCH_SIZE-1];

  logic [IDX_W-1:0] cmp_idx;
  logic             batch_mis;
  logic             err_prior;

  // Batch 0 is checked against its own lane 0, since that lane becomes the block reference.
  always_comb begin
    cmp_idx   = (batch_cnt == '0) ? index_in[0] : ref_idx;
    err_prior = (batch_cnt == '0) ? 1'b0 : err_acc;
    batch_mis = 1'b0;
    for (int i = 0; i < BATCH_SIZE; i++)
      if (index_in[i] != cmp_idx) batch_mis = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batch_cnt <= '0;
      ref_idx   <= '0;
      err_acc   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_err    <= 1'b0;
      // NOTE: pipeline arrays are plain flops, not RAM, so they can and do take the reset.
      for (int i = 0; i < BATCH_SIZE; i++) begin
        s1_real[i] <= '0;
        s1_imag[i] <= '0;
        s1_d[i]    <= '0;
      end
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        batch_cnt <= (batch_cnt == LAST_CNT) ? '0 : batch_cnt + CNT_W'(1);
        if (batch_cnt == '0) ref_idx <= index_in[0];
        err_acc  <= (batch_cnt == LAST_CNT) ? 1'b0 : (err_prior | batch_mis);
        s1_first <= (batch_cnt == '0);
        s1_last  <= (batch_cnt == LAST_CNT);
        s1_err   <= err_prior | batch_mis;
        for (int i = 0; i < BATCH_SIZE; i++) begin
          s1_real[i] <= real_in[i];
          s1_imag[i] <= imag_in[i];
          s1_d[i]    <= TIB_S - $signed({1'b0, index_in[i]});
        end
      end
    end
  end

  for (genvar g = 0; g < BATCH_SIZE; g++) begin : g_lane
    cbfp_lane_scale #(
      .BW_IN(BW_IN), .BW_OUT(BW_OUT), .D_W(D_W), .TARGET_INT_BITS(TARGET_INT_BITS)
    ) u_re (
      .x(s1_real[g]), .d(s1_d[g]), .y(sc_real[g])
    );
    cbfp_lane_scale #(
      .BW_IN(BW_IN), .BW_OUT(BW_OUT), .D_W(D_W), .TARGET_INT_BITS(TARGET_INT_BITS)
    ) u_im (
      .x(s1_imag[g]), .d(s1_d[g]), .y(sc_imag[g])
    );
  end

  // Framing flags are single-cycle pulses; data outputs hold between valid batches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out   <= 1'b0;
      block_start <= 1'b0;
      block_end   <= 1'b0;
      idx_err     <= 1'b0;
      for (int i = 0; i < BATCH_SIZE; i++) begin
        real_out[i] <= '0;
        imag_out[i] <= '0;
      end
    end else begin
      valid_out   <= s1_valid;
      block_start <= s1_valid & s1_first;
      block_end   <= s1_valid & s1_last;
      idx_err     <= s1_valid & s1_last & s1_err;
      if (s1_valid) begin
        for (int i = 0; i < BATCH_SIZE; i++) begin
          real_out[i] <= sc_real[i];
          imag_out[i] <= sc_imag[i];
        end
      end
    end
  end

endmodule
